// File: rtl/systolic_setup_pkg.sv
// Shared constants for the systolic input-skew stage (mirrors def.v defaults).
package systolic_setup_pkg;

  localparam int ARRAY_SIZE       = 8;
  localparam int DEF_DATA_WIDTH   = 8;

  // Lane l is delayed by l+1 register stages.
  function automatic int lane_depth(input int lane);
    return lane + 1;
  endfunction

endpackage

// File: rtl/systolic_setup_if.sv
// Buffer-side strobes/data in, PE-edge skewed lanes out.
interface systolic_setup_if
  import systolic_setup_pkg::*;
#(
  parameter int LANES      = ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                        ensys_i;
  logic                        bubble_i;
  logic [LANES*DATA_WIDTH-1:0] data_i;
  logic [LANES*DATA_WIDTH-1:0] data_o;
  logic [LANES-1:0]            vld_o;
  logic                        busy_o;

  modport master (
    output ensys_i, bubble_i, data_i,
    input  data_o, vld_o, busy_o
  );

  modport slave (
    input  ensys_i, bubble_i, data_i,
    output data_o, vld_o, busy_o
  );
endinterface

// File: rtl/systolic_setup_skew_lane.sv
// DEPTH-stage delay line of {valid, data} tokens with synchronous clear.
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEPTH-1:0]      vld_vec
);

  typedef struct packed {
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
  } tok_t;

  tok_t [DEPTH-1:0] pipe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{vld: in_vld, data: in_data};
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    vld_vec = '0;
    for (int i = 0; i < DEPTH; i++) vld_vec[i] = pipe[i].vld;
  end

  assign out_vld  = pipe[DEPTH-1].vld;
  assign out_data = pipe[DEPTH-1].data;

endmodule

// File: rtl/systolic_setup.sv
// Input skew for the PE array: lane l delayed l+1 cycles, zeros injected in gaps.
module systolic_setup
  import systolic_setup_pkg::*;
#(
  parameter int LANES      = ARRAY_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  systolic_setup_if.slave   bus
);

  logic                              accept;
  logic [LANES-1:0]                  vld_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]  data_q;
  logic [LANES-1:0]                  lane_busy;

  // Bubble beats ensys; gating data here keeps X out of every stage.
  assign accept = bus.ensys_i & ~bus.bubble_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH-1:0]    din;
    logic [lane_depth(l)-1:0] vv;

    assign din = accept ? bus.data_i[l*DATA_WIDTH +: DATA_WIDTH] : '0;

    skew_lane #(
      .DEPTH      (lane_depth(l)),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .in_vld   (accept),
      .in_data  (din),
      .out_vld  (vld_q[l]),
      .out_data (data_q[l]),
      .vld_vec  (vv)
    );

    assign lane_busy[l] = |vv;
  end

  assign bus.data_o = data_q;
  assign bus.vld_o  = vld_q;
  assign bus.busy_o = |lane_busy;

endmodule
